// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen and its consumers (video_gen, DAC, connector).
interface vga_timing_gen_if;
  logic       vga_clk;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       blank_b;
  logic       sync_b;
  logic       frame_start;
  logic [9:0] x;
  logic [9:0] y;

  modport master (
    output vga_clk, pix_en, hsync, vsync, blank_b, sync_b, frame_start, x, y
  );

  modport slave (
    input vga_clk, pix_en, hsync, vsync, blank_b, sync_b, frame_start, x, y
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing: clock divider, h/v counters and registered sync/blank decode.
module vga_timing_gen #(
  parameter int unsigned HACTIVE = 640,
  parameter int unsigned HFP     = 16,
  parameter int unsigned HSYN    = 96,
  parameter int unsigned HBP     = 48,
  parameter int unsigned VACTIVE = 480,
  parameter int unsigned VFP     = 10,
  parameter int unsigned VSYN    = 2,
  parameter int unsigned VBP     = 33,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int unsigned HTOTAL = HACTIVE + HFP + HSYN + HBP;
  localparam int unsigned VTOTAL = VACTIVE + VFP + VSYN + VBP;
  localparam int unsigned HW     = $clog2(HTOTAL);
  localparam int unsigned VW     = $clog2(VTOTAL);
  localparam int unsigned DW     = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF   = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(HACTIVE);
  localparam logic [HW-1:0] H_SYNC_ON  = HW'(HACTIVE + HFP);
  localparam logic [HW-1:0] H_SYNC_OFF = HW'(HACTIVE + HFP + HSYN);
  localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(VACTIVE);
  localparam logic [VW-1:0] V_SYNC_ON  = VW'(VACTIVE + VFP);
  localparam logic [VW-1:0] V_SYNC_OFF = VW'(VACTIVE + VFP + VSYN);

  logic [DW-1:0] divcnt_q, divcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          pix_en_q, vga_clk_q, hsync_q, vsync_q, blank_b_q, frame_start_q;
  logic          h_wrap, frame_wrap;

  always_comb begin
    divcnt_d   = (divcnt_q == DIV_LAST) ? '0 : divcnt_q + 1'b1;
    h_wrap     = pix_en_q && (hcnt_q == H_LAST);
    frame_wrap = h_wrap && (vcnt_q == V_LAST);
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    if (pix_en_q) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
    end
    if (h_wrap) begin
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
  end

  // Decode from next-state counts so sync/blank land on the same edge as x/y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divcnt_q      <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      pix_en_q      <= 1'b0;
      vga_clk_q     <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_b_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      divcnt_q      <= divcnt_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      pix_en_q      <= (divcnt_d == DIV_LAST);
      vga_clk_q     <= (divcnt_q >= DIV_HALF);
      hsync_q       <= !((hcnt_d >= H_SYNC_ON) && (hcnt_d < H_SYNC_OFF));
      vsync_q       <= !((vcnt_d >= V_SYNC_ON) && (vcnt_d < V_SYNC_OFF));
      blank_b_q     <= (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
      frame_start_q <= frame_wrap;
    end
  end

  assign vga.vga_clk     = vga_clk_q;
  assign vga.pix_en      = pix_en_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.blank_b     = blank_b_q;
  assign vga.sync_b      = 1'b0;
  assign vga.frame_start = frame_start_q;
  assign vga.x           = 10'(hcnt_q);
  assign vga.y           = 10'(vcnt_q);

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the system clock.
- Drives the x/y pixel coordinates consumed by the downstream combinational pixel generator (video_gen), plus hsync, vsync, blank and pixel-clock outputs for the video DAC/connector.
- Sits directly upstream of video_gen. r/g/b from video_gen are valid for the x/y presented in the same cycle.

Parameters:
- HACTIVE, 640, visible pixels per line
- HFP, 16, horizontal front porch (pixels)
- HSYN, 96, hsync pulse width (pixels)
- HBP, 48, horizontal back porch (pixels)
- VACTIVE, 480, visible lines per frame
- VFP, 10, vertical front porch (lines)
- VSYN, 2, vsync pulse width (lines)
- VBP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel; legal values are 2 or greater

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- vga_clk  out  1  pixel clock to the DAC
- pix_en  out  1  one-clk strobe; the pixel counter advances on this cycle
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- blank_b  out  1  high inside the active 640x480 area
- sync_b  out  1  DAC composite sync; constant 0
- frame_start  out  1  one-clk pulse when the raster returns to (0,0)
- x  out  10  current horizontal count (hcnt)
- y  out  10  current vertical count (vcnt)

Behaviour:
- Derived totals: HTOTAL = HACTIVE+HFP+HSYN+HBP = 800; VTOTAL = VACTIVE+VFP+VSYN+VBP = 525. All counters are unsigned and just wide enough for their range.
- Divider counter:
  - divcnt counts 0..CLK_DIV-1 and wraps.
  - pix_en = (divcnt == CLK_DIV-1), registered, so it is high for one clk every CLK_DIV clks.
  - vga_clk = (divcnt >= CLK_DIV/2), registered. Its rising edge falls mid-pixel.
- Horizontal counter (hcnt): on each clk with pix_en high, hcnt increments; at HTOTAL-1 it wraps to 0.
- Vertical counter (vcnt): increments only on the clk where hcnt wraps; at VTOTAL-1 it wraps to 0.
- Output decode, all registered from counter values:
  - hsync = 0 iff HACTIVE+HFP <= hcnt < HACTIVE+HFP+HSYN (656..751).
  - vsync = 0 iff VACTIVE+VFP <= vcnt < VACTIVE+VFP+VSYN (490..491).
  - blank_b = (hcnt < HACTIVE) && (vcnt < VACTIVE).
  - Zero relative latency: x, y, hsync, vsync and blank_b always describe the same counter value and change on the same clk edge.
- x = hcnt and y = vcnt over their full range, including blanking. Downstream logic must gate its output with blank_b.
- frame_start is high for exactly one clk: the cycle in which (hcnt, vcnt) first reads (0,0) after both counters wrap. It is not asserted on exit from reset.
- Reset (asynchronous, anytime, including mid-line or mid-frame):
  - divcnt = 0, hcnt = 0, vcnt = 0.
  - pix_en = 0, vga_clk = 0, hsync = 1, vsync = 1, blank_b = 0, sync_b = 0, frame_start = 0, x = 0, y = 0.
- After reset deasserts:
  - First pix_en occurs on clk edge CLK_DIV-1.
  - hcnt first becomes 1 on the edge after that pix_en.
  - blank_b goes to 1 on the first clk edge, with counters at (0,0).
- Simultaneous horizontal and vertical wrap at (799,524): both wrap on the same edge and frame_start fires on that edge. Counters never take values outside their ranges.
- No other inputs exist; behaviour is free-running and deterministic.

Test Plan:
- Reset: hold rst high, toggle clk -> all outputs at reset values. Release rst -> pix_en first high on the 2nd clk; after 2 clks x = 1.
- Line timing (CLK_DIV=2):
  - hsync falls when x becomes 656, stays low 192 clks, rises at x=752.
  - Line period 1600 clks; y increments exactly when x goes 799 -> 0.
- Frame timing:
  - vsync low for exactly 2 lines (y = 490, 491), i.e. 3200 clks.
  - frame_start pulses every 840000 clks, each pulse exactly 1 clk wide.
- Blanking:
  - (639,0) gives blank_b = 1; (640,0) gives 0.
  - (0,479) gives 1; (0,480) gives 0; (799,524) -> (0,0) returns blank_b to 1.
- Async reset mid-frame at (300,200): outputs go to reset values without a clk edge. After release, counting restarts from (0,0) and no spurious frame_start occurs.
- vga_clk: period 2 clks, 50% duty; rising edge one clk after each pix_en, i.e. aligned to mid-pixel.
